// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter: converts single-cycle cache line read/write requests into 4-beat memory bursts
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   line_i / line_o          writeback line from the cache / assembled fill line to the cache
//   address_i, read_i,       cache request (pmem_read / pmem_write), sampled only in IDLE
//   write_i
//   resp_o                   one-cycle completion pulse (pmem_resp)
//   burst_i / burst_o        read beat from memory / write beat to memory
//   address_o                line-aligned burst address
//   read_o, write_o          burst request, held for the whole burst
//   resp_i                   memory beat accept / beat valid strobe
// Optional: define CACHELINE_ADAPTER_PERF_EN to add saturating rd/wr/stall counters.
module cacheline_burst_adapter #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
`ifdef CACHELINE_ADAPTER_PERF_EN
  ,
  output logic [31:0]            rd_count_o,
  output logic [31:0]            wr_count_o,
  output logic [31:0]            stall_count_o
`endif
);
  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int BW = $clog2(BEATS);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  state_e state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [LINE_WIDTH-1:0] buf_q, buf_d, line_q, line_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic busy, last;
  assign busy = state_q == READ || state_q == WRITE;
  assign last = busy && resp_i && beat_q == BW'(BEATS - 1);
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // write_i has priority over read_i; DONE always returns to IDLE before a new request is seen
  always_comb begin
    state_d = state_q == IDLE ? (write_i ? WRITE : read_i ? READ : IDLE)
            : state_q == DONE ? IDLE
            : last ? DONE : state_q;
  end
  always_comb begin
    read_o    = state_q == READ;
    write_o   = state_q == WRITE;
    resp_o    = state_q == DONE;
    burst_o   = write_o ? buf_q[beat_q*BURST_WIDTH +: BURST_WIDTH] : '0;
    address_o = addr_q;
    line_o    = line_q;
  end
  // line_q only changes when a read completes, so line_o holds across intervening writes
  always_comb begin
    beat_d = beat_q;
    buf_d  = buf_q;
    addr_d = addr_q;
    line_d = line_q;
    if (state_q == IDLE && (read_i || write_i)) begin
      addr_d = address_i & ~OFF_MASK;
      beat_d = '0;
      buf_d  = write_i ? line_i : buf_q;
    end
    if (busy && resp_i) begin
      beat_d = beat_q + 1'b1;
      if (state_q == READ) buf_d[beat_q*BURST_WIDTH +: BURST_WIDTH] = burst_i;
    end
    if (last && state_q == READ) line_d = buf_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      buf_q  <= '0;
      addr_q <= '0;
      line_q <= '0;
    end else begin
      beat_q <= beat_d;
      buf_q  <= buf_d;
      addr_q <= addr_d;
      line_q <= line_d;
    end
  end
`ifdef CACHELINE_ADAPTER_PERF_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, st_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      if (last && state_q == READ && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (last && state_q == WRITE && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (busy && !resp_i && st_cnt_q != '1) st_cnt_q <= st_cnt_q + 1'b1;
    end
  end
  assign rd_count_o    = rd_cnt_q;
  assign wr_count_o    = wr_cnt_q;
  assign stall_count_o = st_cnt_q;
`endif
endmodule
